fifo_sync_param: RTL
====================

// Module: fifo_sync_param
// PURPOSE
//  Parametrised single-clock FIFO; next generation of the 8-deep team FIFO.
//  Generalises data width, depth (any depth >= 2, power of two not required) and almost-full/almost-empty thresholds.
//  Keeps the wr_ack/overflow/underflow status protocol; adds a count output.
//  Sits between a producer and a consumer in one clock domain; the team FIFO SVA checker binds to it.
// PARAMETERS
//  DATA_WIDTH        16              width of data_in / data_out
//  FIFO_DEPTH        8               number of entries, >= 2
//  ALMOST_FULL_LVL   FIFO_DEPTH-1    almostfull threshold; ALMOST_EMPTY_LVL < ALMOST_FULL_LVL <= FIFO_DEPTH-1
//  ALMOST_EMPTY_LVL  1               almostempty threshold; 1 <= ALMOST_EMPTY_LVL
//  (local) PTR_W = $clog2(FIFO_DEPTH), CNT_W = $clog2(FIFO_DEPTH+1)
// PORTS
//  clk          in   1           rising-edge clock
//  rst_n        in   1           asynchronous reset, active-low
//  wr_en        in   1           write request
//  rd_en        in   1           read request
//  data_in      in   DATA_WIDTH  write data
//  data_out     out  DATA_WIDTH  read data, registered
//  wr_ack       out  1           registered; previous-cycle write accepted
//  overflow     out  1           registered; previous-cycle write rejected (full)
//  underflow    out  1           registered; previous-cycle read rejected (empty)
//  full         out  1           combinational: count == FIFO_DEPTH
//  empty        out  1           combinational: count == 0
//  almostfull   out  1           combinational: count >= ALMOST_FULL_LVL && !full
//  almostempty  out  1           combinational: count <= ALMOST_EMPTY_LVL && !empty
//  count        out  CNT_W       current occupancy
//  flush        in   1           only when FIFO_FLUSH_EN is defined
// BEHAVIOUR
//  - Reset (rst_n low, async): wr_ptr, rd_ptr, count = 0; data_out, wr_ack, overflow, underflow = 0;
//    empty=1, full=0, almostfull=0, almostempty=0. Memory contents are not reset.
//  - Write accepted when wr_en && !full: mem[wr_ptr] <= data_in; wr_ptr advances; next cycle wr_ack=1, overflow=0.
//  - Write with wr_en && full: no state change; next cycle overflow=1, wr_ack=0.
//  - wr_en low: next cycle wr_ack=0, overflow=0.
//  - Read accepted when rd_en && !empty: data_out <= mem[rd_ptr]; rd_ptr advances; data valid 1 cycle after request.
//  - Read with rd_en && empty: data_out holds; next cycle underflow=1. rd_en low: underflow=0; data_out holds.
//  - Pointer wrap: pointer at FIFO_DEPTH-1 advances to 0 (explicit compare, not modulo 2^PTR_W).
//  - Count: write-only accepted +1; read-only accepted -1;
//    wr&rd both accepted (0 < count < FIFO_DEPTH): count unchanged, both pointers advance;
//    wr&rd when empty: write only, count+1, underflow=1 next cycle;
//    wr&rd when full: read only, count-1, overflow=1 next cycle.
//  - count never exceeds FIFO_DEPTH and never goes below 0; full and empty are never both 1.
//  - Reset asserted mid-operation discards all contents immediately; the first cycle after release behaves as empty.
// CONFIGURATION
//  - FIFO_FLUSH_EN defined: flush port present. flush=1 at a clock edge sets wr_ptr, rd_ptr, count to 0 and
//    wr_ack, overflow, underflow to 0. wr_en/rd_en are ignored that cycle (no ack, no overflow, no underflow).
//    data_out holds. flush has priority over all other activity except reset.
//  - FIFO_FLUSH_EN undefined: no flush port and no flush logic; behaviour otherwise identical.
// TESTING  (defaults DATA_WIDTH=16, FIFO_DEPTH=8 unless noted)
//  1 Reset: drive rst_n=0 mid-traffic with count=5 -> count=0, empty=1, wr_ack/overflow/underflow=0,
//    data_out=0 at once, without waiting for a clock edge.
//  2 Fill/overflow: 8 writes 0x0001..0x0008 -> wr_ack=1 each; almostfull at count=7; full at 8.
//    9th write -> overflow=1, count stays 8.
//  3 Drain/underflow: 8 reads -> data_out 0x0001..0x0008 in order, 1-cycle latency; almostempty at count=1.
//    9th read -> underflow=1, data_out holds 0x0008.
//  4 Simultaneous: wr&rd at empty -> count=1, underflow=1; wr&rd at full -> count=7, overflow=1;
//    wr&rd at count=4 -> count stays 4.
//  5 Wrap, non-power-of-2: FIFO_DEPTH=5, ALMOST_FULL_LVL=3, ALMOST_EMPTY_LVL=2; stream 20 words with
//    interleaved wr/rd -> order preserved across 4 pointer wraps; almostfull at count 3..4; almostempty at 1..2.
//  6 Flush (FIFO_FLUSH_EN): count=6, flush=1 with wr_en=1 -> count=0, empty=1, wr_ack=0 next cycle.
//    Next write 0xBEEF, then read -> data_out=0xBEEF.

Source files
------------

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with registered read data and wr_ack/overflow/underflow status.
// Optional synchronous flush port is enabled by defining FIFO_FLUSH_EN.
module fifo_sync_param #(
   parameter int unsigned DATA_WIDTH       = 16,
   parameter int unsigned FIFO_DEPTH       = 8,
   parameter int unsigned ALMOST_FULL_LVL  = FIFO_DEPTH - 1,
   parameter int unsigned ALMOST_EMPTY_LVL = 1,
   localparam int unsigned PTR_W           = $clog2(FIFO_DEPTH),
   localparam int unsigned CNT_W           = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  wr_ack,
   output logic                  overflow,
   output logic                  underflow,
   output logic                  full,
   output logic                  empty,
   output logic                  almostfull,
   output logic                  almostempty,
   output logic [CNT_W-1:0]      count
`ifdef FIFO_FLUSH_EN
   ,
   input  logic                  flush
`endif
);

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
   logic                  wr_ack_q, wr_ack_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;
   logic                  wr_acc, rd_acc;

   assign full        = (count_q == CNT_W'(FIFO_DEPTH));
   assign empty       = (count_q == '0);
   assign almostfull  = (count_q >= CNT_W'(ALMOST_FULL_LVL)) && !full;
   assign almostempty = (count_q <= CNT_W'(ALMOST_EMPTY_LVL)) && !empty;

   // Acceptance looks only at the current occupancy, so a read at full frees no slot this cycle.
`ifdef FIFO_FLUSH_EN
   assign wr_acc = wr_en && !full && !flush;
   assign rd_acc = rd_en && !empty && !flush;
`else
   assign wr_acc = wr_en && !full;
   assign rd_acc = rd_en && !empty;
`endif

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      data_out_d  = data_out_q;
      wr_ack_d    = wr_acc;
      overflow_d  = wr_en && full;
      underflow_d = rd_en && empty;

      // Explicit wrap so non-power-of-two depths work.
      if (wr_acc) begin
         wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (rd_acc) begin
         rd_ptr_d   = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
         data_out_d = mem[rd_ptr_q];
      end

      unique case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

`ifdef FIFO_FLUSH_EN
      if (flush) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         count_d     = '0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         data_out_q  <= '0;
         wr_ack_q    <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         data_out_q  <= data_out_d;
         wr_ack_q    <= wr_ack_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wr_ptr_q] <= data_in;
      end
   end

   assign data_out  = data_out_q;
   assign wr_ack    = wr_ack_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;
   assign count     = count_q;

endmodule
